// File: rtl/spi_cache_arb.sv
`default_nettype none
// ============================================================================
//  Module   : spi_cache_arb
//  Purpose  : Two-master AXI4-Lite read arbiter in front of the SPI cache.
//             Master 0 (instruction fetch) and master 1 (data read) share
//             the single cache read port. Round-robin grant, one transaction
//             outstanding at a time, registered address toward the cache,
//             combinational read-data return to the granted master.
//  Ports    : aclk / aresetn      - clock, asynchronous active-low reset
//             m0_* / m1_*         - AR and R channels of the two masters
//             s_*                 - AR and R channels toward the cache
//             grant               - index of current or last granted master
//             busy                - high while a transaction is in flight
//  Revision : 1.0 - initial release
// ============================================================================
module spi_cache_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  output logic              grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_grant;
  logic              r_last;
  logic              w_winner;
  logic              w_accept;
  logic              w_granted_rready;

  // On a tie the master not served last wins; a lone requester always wins.
  // arready is combinational from arvalid, so it is gated with aresetn to
  // keep every ready low while reset is held.
  always_comb begin
    w_winner = (m0_arvalid && m1_arvalid) ? ~r_last : m1_arvalid;
    w_accept = aresetn && (r_state == ST_IDLE) && (m0_arvalid || m1_arvalid);
    w_granted_rready = r_grant ? m1_rready : m0_rready;
  end

  always_comb begin
    w_state_nxt = r_state;
    m0_arready  = 1'b0;
    m1_arready  = 1'b0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    m0_rvalid   = 1'b0;
    m1_rvalid   = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    m0_rresp    = 2'b00;
    m1_rresp    = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          m0_arready  = ~w_winner;
          m1_arready  = w_winner;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        // Zero-latency pass-through; the non-granted master sees all zeros.
        s_rready = w_granted_rready;
        if (r_grant) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
        end
        if (s_rvalid && w_granted_rready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr  <= w_winner ? m1_araddr : m0_araddr;
        r_grant <= w_winner;
        r_last  <= w_winner;
      end
    end
  end

  assign s_araddr = r_addr;
  assign grant    = r_grant;
  assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_cache_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_cache_arb
//  Purpose  : Self-checking bench for spi_cache_arb. Two master agents fed
//             from address queues, a cache responder with programmable
//             address/data latency, and a scoreboard of expected read beats.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cache_arb;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [ADDR_W-1:0] m0_araddr;
  logic [DATA_W-1:0] m0_rdata;
  logic [1:0]        m0_rresp;
  logic              m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [ADDR_W-1:0] m1_araddr;
  logic [DATA_W-1:0] m1_rdata;
  logic [1:0]        m1_rresp;
  logic              s_arvalid, s_arready, s_rvalid, s_rready;
  logic [ADDR_W-1:0] s_araddr;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              grant, busy;

  always #5 aclk = ~aclk;

  spi_cache_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .grant(grant), .busy(busy)
  );

  typedef struct {
    bit          m;
    logic [31:0] data;
    logic [1:0]  resp;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] m0_q[$];
  logic [31:0] m1_q[$];
  logic [31:0] addr_log[$];
  bit          grant_log[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ar_wait = 0, r_wait = 0, ar_cnt = 0, r_cnt = 0;
  bit r_busy = 1'b0;
  logic [31:0] c_addr = '0;
  int m0_done = 0, m1_done = 0, m0_rhs_cyc = -1, m1_acc_cyc = -1;

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_masters();
    m0_arvalid = (m0_q.size() > 0);
    m0_araddr  = m0_arvalid ? m0_q[0] : '0;
    m1_arvalid = (m1_q.size() > 0);
    m1_araddr  = m1_arvalid ? m1_q[0] : '0;
  endtask

  function automatic bit is_done();
    return (sb.size() == 0) && (m0_q.size() == 0) && (m1_q.size() == 0) && !busy && !r_busy;
  endfunction

  // Called a little after a falling edge: evaluates the handshakes that the
  // next rising edge will complete, checks any read beat on offer, then
  // advances the agents at the following falling edge.
  task automatic step();
    bit ar_hs0, ar_hs1, s_ar_hs, r_hs0, r_hs1, s_r_hs;
    logic [31:0] cur_s_addr;
    sb_t e;
    ar_hs0     = m0_arvalid && m0_arready;
    ar_hs1     = m1_arvalid && m1_arready;
    s_ar_hs    = s_arvalid && s_arready;
    r_hs0      = m0_rvalid && m0_rready;
    r_hs1      = m1_rvalid && m1_rready;
    s_r_hs     = s_rvalid && s_rready;
    cur_s_addr = s_araddr;
    if (ar_hs0) sb.push_back('{1'b0, exp_data(m0_araddr), m0_araddr[5:4]});
    if (ar_hs1) begin
      sb.push_back('{1'b1, exp_data(m1_araddr), m1_araddr[5:4]});
      m1_acc_cyc = cyc;
    end
    if (s_ar_hs) begin
      addr_log.push_back(s_araddr);
      grant_log.push_back(grant);
    end
    if (m0_rvalid || m1_rvalid) begin
      chk("rvalid_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb[0];
        chk("rvalid_route", {m0_rvalid, m1_rvalid}, e.m ? 2'b01 : 2'b10);
        if (e.m) begin
          chk("m1_rdata", m1_rdata, e.data);
          chk("m1_rresp", m1_rresp, e.resp);
          chk("m0_r_quiet", {m0_rdata, m0_rresp}, 0);
          chk("s_rready_m1", s_rready, m1_rready);
        end else begin
          chk("m0_rdata", m0_rdata, e.data);
          chk("m0_rresp", m0_rresp, e.resp);
          chk("m1_r_quiet", {m1_rdata, m1_rresp}, 0);
          chk("s_rready_m0", s_rready, m0_rready);
        end
        if (r_hs0 || r_hs1) begin
          void'(sb.pop_front());
          if (r_hs0) begin
            m0_done++;
            m0_rhs_cyc = cyc;
          end else begin
            m1_done++;
          end
        end
      end
    end
    @(negedge aclk);
    cyc++;
    if (ar_hs0) void'(m0_q.pop_front());
    if (ar_hs1) void'(m1_q.pop_front());
    drive_masters();
    if (s_r_hs) begin
      s_rvalid = 1'b0;
      s_rdata  = '0;
      s_rresp  = 2'b00;
      r_busy   = 1'b0;
    end
    if (s_ar_hs) begin
      r_busy = 1'b1;
      r_cnt  = 0;
      c_addr = cur_s_addr;
    end
    if (r_busy && !s_rvalid) begin
      if (r_cnt >= r_wait) begin
        s_rvalid = 1'b1;
        s_rdata  = exp_data(c_addr);
        s_rresp  = c_addr[5:4];
      end else begin
        r_cnt++;
      end
    end
    if (s_arvalid) begin
      if (ar_cnt >= ar_wait) s_arready = 1'b1;
      else begin
        s_arready = 1'b0;
        ar_cnt++;
      end
    end else begin
      s_arready = 1'b0;
      ar_cnt    = 0;
    end
    #1;
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while (!is_done() && n < limit) begin
      step();
      n++;
    end
    chk(tag, is_done(), 1);
  endtask

  task automatic clear_cache_agent();
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = 2'b00;
    r_busy    = 1'b0;
    ar_cnt    = 0;
    r_cnt     = 0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    m0_q.delete();
    m1_q.delete();
    sb.delete();
    drive_masters();
    clear_cache_agent();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    clear_cache_agent();
    // Both masters requesting while reset is held: nothing may be accepted.
    m0_arvalid = 1'b1; m0_araddr = 32'h44;
    m1_arvalid = 1'b1; m1_araddr = 32'h88;
    #12;
    chk("reset_handshakes", {m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready}, 0);
    chk("reset_state", {busy, grant, s_araddr}, 0);
    do_reset();
    chk("post_reset_state", {busy, grant, s_araddr}, 0);

    // Single m0 read, cache one cycle late on both channels.
    ar_wait = 1; r_wait = 1;
    m0_q.push_back(32'h0000_1000);
    drive_masters(); #1;
    chk("t1_m0_arready", {m0_arready, m1_arready}, 2'b10);
    step();
    chk("t1_addr_phase", {s_arvalid, busy, grant, m0_arready}, 4'b1100);
    chk("t1_s_araddr", s_araddr, 32'h1000);
    drain("t1_drain", 50);
    chk("t1_done", {m0_done[7:0], m1_done[7:0]}, 16'h0100);
    chk("t1_grant", grant, 0);

    // Simultaneous requests straight out of reset.
    do_reset();
    addr_log.delete(); grant_log.delete();
    m0_rhs_cyc = -1; m1_acc_cyc = -1;
    ar_wait = 0; r_wait = 0;
    m0_q.push_back(32'h10);
    m1_q.push_back(32'h20);
    drive_masters(); #1;
    chk("t2_tie_winner", {m0_arready, m1_arready}, 2'b10);
    drain("t2_drain", 50);
    chk("t2_count", addr_log.size(), 2);
    chk("t2_addr0", addr_log[0], 32'h10);
    chk("t2_addr1", addr_log[1], 32'h20);
    chk("t2_grants", {grant_log[0], grant_log[1]}, 2'b01);
    chk("t2_m1_accept_cycle", m1_acc_cyc, m0_rhs_cyc + 1);

    // Fairness: both masters request back to back for eight transactions.
    addr_log.delete(); grant_log.delete();
    m0_done = 0; m1_done = 0;
    for (int i = 0; i < 4; i++) begin
      m0_q.push_back(32'h100 + 32'(i * 4));
      m1_q.push_back(32'h200 + 32'(i * 4));
    end
    drive_masters(); #1;
    drain("t3_drain", 200);
    chk("t3_count", grant_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("t3_grant_alternates", grant_log[i], i % 2);
    chk("t3_done", {m0_done[7:0], m1_done[7:0]}, 16'h0404);

    // Address backpressure then read-data backpressure on an m1 read.
    addr_log.delete(); grant_log.delete();
    ar_wait = 5; r_wait = 0; m1_rready = 1'b0;
    m1_q.push_back(32'h300);
    drive_masters(); #1;
    chk("t4_m1_arready", {m0_arready, m1_arready}, 2'b01);
    step();
    m0_q.push_back(32'h400);
    drive_masters(); #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_ar_hold", {s_arvalid, m0_arready, m1_arready}, 3'b100);
      chk("t4_ar_addr", s_araddr, 32'h300);
      step();
    end
    ar_wait = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t4_r_stall", {m1_rvalid, s_rready, busy}, 3'b101);
      step();
    end
    m1_rready = 1'b1; #1;
    drain("t4_drain", 50);
    chk("t4_addr_order", {addr_log[0], addr_log[1]}, {32'h300, 32'h400});

    // Stray cache response while idle.
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678; s_rresp = 2'b10; #1;
    chk("t5_stray", {m0_rvalid, m1_rvalid, s_rready, busy}, 0);
    step();
    chk("t5_stray_after", {m0_rvalid, m1_rvalid, s_rready, busy}, 0);
    s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; #1;

    // Reset asserted in the middle of a read.
    r_wait = 3;
    m0_q.push_back(32'h500);
    drive_masters(); #1;
    begin
      int n = 0;
      while (!(busy && !s_arvalid) && n < 20) begin
        step();
        n++;
      end
    end
    chk("t6_in_data", busy && !s_arvalid, 1);
    m1_q.push_back(32'h600);
    drive_masters();
    aresetn = 1'b0; #1;
    chk("t6_reset_handshakes", {m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready}, 0);
    chk("t6_reset_state", {busy, grant, s_araddr}, 0);
    sb.delete();
    clear_cache_agent();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1; #1;
    chk("t6_m1_alone", {m0_arready, m1_arready}, 2'b01);
    step();
    chk("t6_m1_grant", {grant, s_araddr}, {1'b1, 32'h600});
    drain("t6_drain1", 50);
    m0_q.push_back(32'h700);
    m1_q.push_back(32'h800);
    drive_masters(); #1;
    chk("t6_tie_winner", {m0_arready, m1_arready}, 2'b10);
    step();
    chk("t6_m0_grant", {grant, s_araddr}, {1'b0, 32'h700});
    drain("t6_drain2", 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
